// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Parametrised register file. It has NRD combinational read ports,
//            two write ports, and a saturating pending-write scoreboard.
//            Optional macro RF_WRITE_BYPASS_EN: same-cycle write data and busy
//            clearing are forwarded to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int NRD    = 3,
    parameter int PC_IDX = 15,
    parameter int PEND_W = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD*AW-1:0]           ra,
    output logic [NRD*DATA_W-1:0]       rd,
    output logic [NRD-1:0]              rd_busy,
    input  logic [DATA_W-1:0]           r15,
    input  logic                        we3,
    input  logic [AW-1:0]               wa3,
    input  logic [DATA_W-1:0]           wd3,
    input  logic                        we4,
    input  logic [AW-1:0]               wa4,
    input  logic [DATA_W-1:0]           wd4,
    input  logic                        iss_v,
    input  logic [AW-1:0]               iss_reg,
    output logic                        iss_full,
    output logic [(NREGS-1)*DATA_W-1:0] rf_out
);

    localparam logic [AW-1:0]     PC_A     = AW'(PC_IDX);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DATA_W-1:0] regs     [NREGS];
    logic [PEND_W-1:0] pend     [NREGS];
    logic [PEND_W-1:0] pend_nxt [NREGS];
    logic [NREGS-1:0]  hit3_v;
    logic [NREGS-1:0]  hit4_v;

    for (genvar i = 0; i < NREGS; i++) begin : g_pend
        if (i == PC_IDX) begin : g_pc
            assign hit3_v[i]   = 1'b0;
            assign hit4_v[i]   = 1'b0;
            assign pend_nxt[i] = '0;
        end else begin : g_arch
            logic              inc;
            logic [PEND_W-1:0] sum;
            assign hit3_v[i] = we3 && (wa3 == AW'(i));
            assign hit4_v[i] = we4 && (wa4 == AW'(i));
            // A dual-port write retires only one producer, and an issue that
            // coincides with it is absorbed, so the net change is -1.
            assign inc = iss_v && (iss_reg == AW'(i)) && (pend[i] != PEND_MAX)
                         && !(hit3_v[i] && hit4_v[i]);
            assign sum = pend[i] + PEND_W'(inc);
            assign pend_nxt[i] = ((hit3_v[i] || hit4_v[i]) && (sum != '0))
                                 ? sum - PEND_W'(1) : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (hit3_v[i]) begin
                    regs[i] <= wd3;
                end else if (hit4_v[i]) begin
                    regs[i] <= wd4;
                end
                pend[i] <= pend_nxt[i];
            end
        end
    end

    assign iss_full = (iss_reg != PC_A) && (pend[iss_reg] == PEND_MAX);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              busy;
        assign addr = ra[k*AW +: AW];
        always_comb begin
            data = regs[addr];
            busy = (pend[addr] != '0);
`ifdef RF_WRITE_BYPASS_EN
            if (hit3_v[addr]) begin
                data = wd3;
            end else if (hit4_v[addr]) begin
                data = wd4;
            end
            if (hit3_v[addr] || hit4_v[addr]) begin
                busy = (pend_nxt[addr] != '0);
            end
`endif
            if (addr == PC_A) begin
                data = r15;
                busy = 1'b0;
            end
        end
        assign rd[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]             = busy;
    end

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_dump
        assign rf_out[(NREGS-2-i)*DATA_W +: DATA_W] = regs[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Scoreboard bench for regfile_sb. Directed stimulus queues the
//            expected values, and a negedge monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD = 0, K_BUSY = 1, K_FULL = 2, K_RF = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  ra;
    logic [95:0]  rd;
    logic [2:0]   rd_busy;
    logic [31:0]  r15;
    logic         we3, we4, iss_v;
    logic [3:0]   wa3, wa4, iss_reg;
    logic [31:0]  wd3, wd4;
    logic         iss_full;
    logic [479:0] rf_out;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    regfile_sb dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .r15(r15), .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4),
        .wd4(wd4), .iss_v(iss_v), .iss_reg(iss_reg), .iss_full(iss_full),
        .rf_out(rf_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] actual(int kind, int idx);
        case (kind)
            K_RD:    return rd[idx*32 +: 32];
            K_BUSY:  return {31'b0, rd_busy[idx]};
            K_FULL:  return {31'b0, iss_full};
            default: return rf_out[(14-idx)*32 +: 32];
        endcase
    endfunction

    // Monitor: retire every expectation queued for the current cycle.
    initial forever begin
        exp_t        e;
        logic [31:0] act;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.kind, e.idx);
            n_vec++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (cycle %0d/%0d)",
                         e.name, act, e.exp, cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic expect_v(int kind, int idx, logic [31:0] v, string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.idx = idx; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle();
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        we4 = 1'b0; wa4 = '0; wd4 = '0;
        iss_v = 1'b0; iss_reg = '0;
    endtask

    task automatic set_ra(int k, int a);
        ra[k*4 +: 4] = 4'(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(int r);
        iss_v = 1'b1; iss_reg = 4'(r);
    endtask

    task automatic wr3(int r, logic [31:0] d);
        we3 = 1'b1; wa3 = 4'(r); wd3 = d;
    endtask

    task automatic wr4(int r, logic [31:0] d);
        we4 = 1'b1; wa4 = 4'(r); wd4 = d;
    endtask

    initial begin
        ra = '0; r15 = 32'h0000_0108; idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Reset state: every stored register reads 0 and is idle.
        for (int base = 0; base < 15; base += 3) begin
            for (int k = 0; k < 3; k++) begin
                set_ra(k, base + k);
                expect_v(K_RD, k, 32'h0, $sformatf("reset_rd_r%0d", base + k));
                expect_v(K_BUSY, k, 32'h0, $sformatf("reset_busy_r%0d", base + k));
            end
            step();
        end
        set_ra(0, 15);
        issue(0);
        expect_v(K_RD, 0, 32'h0000_0108, "pc_read_r15");
        expect_v(K_BUSY, 0, 32'h0, "pc_busy");
        expect_v(K_FULL, 0, 32'h0, "reset_iss_full");
        expect_v(K_RF, 0, 32'h0, "reset_rf_r0");
        expect_v(K_RF, 14, 32'h0, "reset_rf_r14");
        step();
        // Undo the issue to r0 so its counter is back to 0.
        wr3(0, 32'h0);
        step();

        // Write r3, read it in the same cycle and the next one.
        wr3(3, 32'hDEAD_BEEF); set_ra(0, 3);
        expect_v(K_RD, 0, BYP ? 32'hDEAD_BEEF : 32'h0, "wr_r3_same_cycle");
        step();
        set_ra(0, 3);
        expect_v(K_RD, 0, 32'hDEAD_BEEF, "wr_r3_next_cycle");
        expect_v(K_RF, 3, 32'hDEAD_BEEF, "rf_out_r3");
        step();

        // Dual write to r5 with two producers outstanding.
        issue(5); step();
        issue(5); step();
        wr3(5, 32'h11); wr4(5, 32'h22); set_ra(0, 5);
        expect_v(K_RD, 0, BYP ? 32'h11 : 32'h0, "dual_wr_r5_same");
        expect_v(K_BUSY, 0, 32'h1, "dual_wr_r5_busy_cnt2");
        step();
        set_ra(0, 5);
        expect_v(K_RD, 0, 32'h11, "dual_wr_r5_port_a_wins");
        expect_v(K_BUSY, 0, 32'h1, "dual_wr_r5_cnt1");
        wr4(5, 32'h33);
        expect_v(K_BUSY, 0, BYP ? 32'h0 : 32'h1, "wr_r5_last_busy");
        step();
        set_ra(0, 5);
        expect_v(K_RD, 0, 32'h33, "wr_r5_port_b");
        expect_v(K_BUSY, 0, 32'h0, "r5_idle");
        step();

        // Fill r7's counter, refuse the fourth issue, then drain it.
        set_ra(1, 7);
        for (int n = 0; n < 3; n++) begin
            issue(7); set_ra(1, 7);
            expect_v(K_FULL, 0, 32'h0, $sformatf("r7_issue%0d_not_full", n));
            expect_v(K_BUSY, 1, (n == 0) ? 32'h0 : 32'h1, $sformatf("r7_busy_before_issue%0d", n));
            step();
        end
        issue(7); set_ra(1, 7);
        expect_v(K_FULL, 0, 32'h1, "r7_fourth_issue_full");
        expect_v(K_BUSY, 1, 32'h1, "r7_busy_cnt3");
        step();
        for (int n = 0; n < 3; n++) begin
            wr3(7, 32'h70 + n); set_ra(1, 7);
            expect_v(K_BUSY, 1, (BYP && n == 2) ? 32'h0 : 32'h1,
                     $sformatf("r7_busy_wb%0d", n));
            step();
        end
        set_ra(1, 7);
        expect_v(K_BUSY, 1, 32'h0, "r7_drained");
        expect_v(K_RD, 1, 32'h72, "r7_last_wb_data");
        step();

        // Issue and writeback to r2 in the same cycle cancel out.
        issue(2); step();
        issue(2); wr3(2, 32'h2222); set_ra(2, 2);
        expect_v(K_BUSY, 2, 32'h1, "r2_issue_wr_busy");
        step();
        set_ra(2, 2);
        expect_v(K_RD, 2, 32'h2222, "r2_updated");
        expect_v(K_BUSY, 2, 32'h1, "r2_cnt_still1");
        wr4(2, 32'h2223);
        step();
        set_ra(2, 2);
        expect_v(K_BUSY, 2, 32'h0, "r2_cnt0");
        expect_v(K_RD, 2, 32'h2223, "r2_port_b_data");
        step();

        // Reset wins over a concurrent write.
        wr3(4, 32'h55); step();
        issue(4); step();
        issue(4); step();
        set_ra(0, 4);
        expect_v(K_RD, 0, 32'h55, "r4_pre_reset");
        expect_v(K_BUSY, 0, 32'h1, "r4_busy_pre_reset");
        step();
        reset = 1'b1; wr3(4, 32'h66);
        @(posedge clk); #1; idle();
        reset = 1'b0;
        set_ra(0, 4);
        expect_v(K_RD, 0, 32'h0, "r4_after_reset");
        expect_v(K_BUSY, 0, 32'h0, "r4_cnt_after_reset");
        step();

        // Writes and issues aimed at the PC slot are ignored.
        wr3(15, 32'hFFFF_FFFF); wr4(15, 32'hAAAA_5555);
        issue(15); r15 = 32'h0000_0200; set_ra(0, 15);
        expect_v(K_FULL, 0, 32'h0, "pc_issue_not_full");
        expect_v(K_RD, 0, 32'h0000_0200, "pc_read_during_write");
        step();
        set_ra(0, 15);
        expect_v(K_RD, 0, 32'h0000_0200, "pc_read_after_write");
        expect_v(K_BUSY, 0, 32'h0, "pc_busy_after_issue");
        for (int i = 0; i < 15; i++) begin
            expect_v(K_RF, i, 32'h0, $sformatf("rf_out_r%0d_after_pc_write", i));
        end
        step();

        repeat (3) step();
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
